fsk_bit_framer: RTL and testbench

//  Upstream bit source for the FSK sine modulator. Accepts bytes on a valid/ready port, buffers

---
 rtl/fsk_bit_framer.sv | 147 ++++++++++++++
 tb/tb_fsk_bit_framer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/fsk_bit_framer.sv
// fsk_bit_framer: byte FIFO + UART-style framer feeding one bit per symbol to an FSK modulator
//
// Ports:
//   clk         system clock, all logic on posedge
//   reset       synchronous, active-low reset
//   din         byte to transmit
//   din_valid   din is valid this cycle
//   din_ready   FIFO can accept (write when din_valid && din_ready)
//   dado        current symbol bit to the modulator (registered)
//   sym_start   one-cycle pulse in the first cycle of each symbol (registered)
//   busy        frame in progress or FIFO non-empty (registered)
//   fifo_level  bytes currently buffered
module fsk_bit_framer #(
    parameter int SYMBOL_LEN = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int PARITY_EN  = 0
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [7:0]                           din,
    input  logic                                 din_valid,
    output logic                                 din_ready,
    output logic                                 dado,
    output logic                                 sym_start,
    output logic                                 busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_level
);
    localparam int CW = $clog2(SYMBOL_LEN);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = $clog2(FIFO_DEPTH + 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    logic [CW-1:0] sym_cnt_q, sym_cnt_d;
    logic [2:0]    state_q, state_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic          dado_q, dado_d;
    logic          sym_start_q, sym_start_d;
    logic          busy_q, busy_d;
    logic [LW-1:0] level_q, level_d;
    logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [7:0]    mem [FIFO_DEPTH];
    logic          boundary, push, pop;

    always_comb begin
        boundary    = sym_cnt_q == CW'(SYMBOL_LEN - 1);
        din_ready   = level_q != LW'(FIFO_DEPTH);
        push        = din_valid && din_ready;
        // pop uses the pre-edge level, so a byte pushed on a boundary edge waits a symbol
        pop         = boundary && (state_q == IDLE || state_q == STOP) && level_q != '0;
        sym_cnt_d   = boundary ? '0 : sym_cnt_q + CW'(1);
        sym_start_d = boundary;
        level_d     = level_q + LW'(push) - LW'(pop);
        rd_d        = rd_q + PW'(pop);
        wr_d        = wr_q + PW'(push);
        state_d     = state_q;
        shift_d     = shift_q;
        par_d       = par_q;
        bit_idx_d   = bit_idx_q;
        dado_d      = dado_q;
        if (boundary) begin
            case (state_q)
                IDLE, STOP: begin
                    if (pop) begin
                        shift_d = mem[rd_q];
                        par_d   = ^mem[rd_q];
                        dado_d  = 1'b0;
                        state_d = START;
                    end else begin
                        dado_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
                START: begin
                    dado_d    = shift_q[0];
                    bit_idx_d = 3'd0;
                    state_d   = DATA;
                end
                DATA: begin
                    if (bit_idx_q != 3'd7) begin
                        shift_d   = shift_q >> 1;
                        bit_idx_d = bit_idx_q + 3'd1;
                        dado_d    = shift_q[1];
                    end else if (PARITY_EN != 0) begin
                        dado_d  = par_q;
                        state_d = PARITY;
                    end else begin
                        dado_d  = 1'b1;
                        state_d = STOP;
                    end
                end
                PARITY: begin
                    dado_d  = 1'b1;
                    state_d = STOP;
                end
                default: begin
                    dado_d  = 1'b1;
                    state_d = IDLE;
                end
            endcase
        end
        busy_d = state_d != IDLE || level_d != '0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sym_cnt_q   <= '0;
            state_q     <= IDLE;
            shift_q     <= '0;
            par_q       <= 1'b0;
            bit_idx_q   <= '0;
            dado_q      <= 1'b1;
            sym_start_q <= 1'b0;
            busy_q      <= 1'b0;
            level_q     <= '0;
            rd_q        <= '0;
            wr_q        <= '0;
        end else begin
            sym_cnt_q   <= sym_cnt_d;
            state_q     <= state_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            bit_idx_q   <= bit_idx_d;
            dado_q      <= dado_d;
            sym_start_q <= sym_start_d;
            busy_q      <= busy_d;
            level_q     <= level_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && push) mem[wr_q] <= din;
    end

    assign dado       = dado_q;
    assign sym_start  = sym_start_q;
    assign busy       = busy_q;
    assign fifo_level = level_q;
endmodule

// File: tb/tb_fsk_bit_framer.sv
// tb_fsk_bit_framer: random and directed stimulus against a frame-level reference model
module tb_fsk_bit_framer;
    localparam int L = 32;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] din = '0;
    logic       din_valid = 1'b0;
    logic       din_ready_o [2];
    logic       dado_o [2];
    logic       sym_start_o [2];
    logic       busy_o [2];
    logic [2:0] level_o [2];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fsk_bit_framer #(.SYMBOL_LEN(L), .FIFO_DEPTH(D), .PARITY_EN(0)) u0 (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
        .din_ready(din_ready_o[0]), .dado(dado_o[0]), .sym_start(sym_start_o[0]),
        .busy(busy_o[0]), .fifo_level(level_o[0]));

    fsk_bit_framer #(.SYMBOL_LEN(L), .FIFO_DEPTH(D), .PARITY_EN(1)) u1 (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
        .din_ready(din_ready_o[1]), .dado(dado_o[1]), .sym_start(sym_start_o[1]),
        .busy(busy_o[1]), .fifo_level(level_o[1]));

    // reference model: every accepted byte is logged; a frame is a symbol index into that byte
    logic [7:0] log_m [2][0:8191];
    int         wr_m [2];
    int         rd_m [2];
    int         pos_m [2];
    bit         act_m [2];
    logic [7:0] cur_m [2];
    logic       dado_m [2];
    logic       busy_m [2];
    bit         pushed_m [2];
    int         cnt_m = 0;
    logic       ss_m = 1'b0;
    logic       cap0 [$];
    logic       cap1 [$];

    function automatic logic sym_of(logic [7:0] b, int p, int par);
        if (p == 0) return 1'b0;
        if (p <= 8) return b[p-1];
        if (p == 9 && par != 0) return ^b;
        return 1'b1;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        bit bnd;
        int lvl;
        if (!reset) begin
            cnt_m = 0;
            ss_m  = 1'b0;
            for (int k = 0; k < 2; k++) begin
                rd_m[k] = wr_m[k];
                act_m[k] = 1'b0;
                dado_m[k] = 1'b1;
                busy_m[k] = 1'b0;
                pushed_m[k] = 1'b0;
            end
        end else begin
            bnd   = cnt_m == L - 1;
            cnt_m = bnd ? 0 : cnt_m + 1;
            ss_m  = bnd;
            for (int k = 0; k < 2; k++) begin
                lvl = wr_m[k] - rd_m[k];
                pushed_m[k] = din_valid && lvl != D;
                if (bnd) begin
                    if (act_m[k] && pos_m[k] + 1 < (k == 1 ? 11 : 10)) begin
                        pos_m[k]++;
                        dado_m[k] = sym_of(cur_m[k], pos_m[k], k);
                    end else if (lvl > 0) begin
                        cur_m[k] = log_m[k][rd_m[k]];
                        rd_m[k]++;
                        pos_m[k] = 0;
                        act_m[k] = 1'b1;
                        dado_m[k] = 1'b0;
                    end else begin
                        act_m[k] = 1'b0;
                        dado_m[k] = 1'b1;
                    end
                end
                if (pushed_m[k]) begin
                    log_m[k][wr_m[k]] = din;
                    wr_m[k]++;
                end
                busy_m[k] = act_m[k] || (wr_m[k] - rd_m[k]) != 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("dado%0d", k), 32'(dado_o[k]), 32'(dado_m[k]));
            check($sformatf("sym_start%0d", k), 32'(sym_start_o[k]), 32'(ss_m));
            check($sformatf("busy%0d", k), 32'(busy_o[k]), 32'(busy_m[k]));
            check($sformatf("level%0d", k), 32'(level_o[k]), 32'(wr_m[k] - rd_m[k]));
            check($sformatf("din_ready%0d", k), 32'(din_ready_o[k]), 32'((wr_m[k] - rd_m[k]) != D));
        end
        if (sym_start_o[0]) cap0.push_back(dado_o[0]);
        if (sym_start_o[1]) cap1.push_back(dado_o[1]);
    endtask

    task automatic wait_cnt(input int c);
        for (int g = 0; g < 2 * L && cnt_m != c; g++) tick();
    endtask

    task automatic drain();
        for (int g = 0; g < 8000 && (busy_m[0] || busy_m[1]); g++) tick();
        check("drain_busy0", 32'(busy_o[0]), 32'd0);
        check("drain_busy1", 32'(busy_o[1]), 32'd0);
    endtask

    logic exp_a5 [11] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1, 1};
    logic exp_par [22] = '{0, 1, 1, 1, 0, 0, 0, 0, 0, 1, 1,
                           0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1};

    initial begin
        for (int k = 0; k < 2; k++) begin
            wr_m[k] = 0; rd_m[k] = 0; pos_m[k] = 0; act_m[k] = 1'b0;
            cur_m[k] = '0; dado_m[k] = 1'b1; busy_m[k] = 1'b0; pushed_m[k] = 1'b0;
        end
        repeat (3) tick();
        reset = 1'b1;
        repeat (200) tick();

        // single 0xA5 frame, written away from a boundary
        wait_cnt(5);
        din = 8'hA5; din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        cap0.delete();
        repeat (11 * L + 8) tick();
        for (int i = 0; i < 11; i++)
            check($sformatf("a5_sym%0d", i), i < cap0.size() ? 32'(cap0[i]) : 32'hEE, 32'(exp_a5[i]));
        drain();

        // parity frames 0x07 then 0x03, back to back
        wait_cnt(5);
        din = 8'h07; din_valid = 1'b1;
        tick();
        din = 8'h03;
        tick();
        din_valid = 1'b0;
        cap1.delete();
        repeat (22 * L + 8) tick();
        for (int i = 0; i < 22; i++)
            check($sformatf("par_sym%0d", i), i < cap1.size() ? 32'(cap1[i]) : 32'hEE, 32'(exp_par[i]));
        drain();

        // hold din_valid for 6 bytes
        begin
            int acc = 0;
            for (int g = 0; g < 3000 && acc < 6; g++) begin
                din = 8'(8'h30 + acc); din_valid = 1'b1;
                tick();
                if (pushed_m[0]) acc++;
            end
            din_valid = 1'b0;
            check("hold_accepted", 32'(acc), 32'd6);
        end
        drain();

        // reset mid-DATA with bytes queued
        wait_cnt(5);
        for (int i = 0; i < 4; i++) begin
            din = 8'($urandom); din_valid = 1'b1;
            tick();
        end
        din_valid = 1'b0;
        repeat (3 * L + 10) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("rst_dado", 32'(dado_o[0]), 32'd1);
        check("rst_level", 32'(level_o[0]), 32'd0);
        check("rst_busy", 32'(busy_o[0]), 32'd0);
        repeat (L + 4) tick();

        // random traffic with varying load and occasional resets
        for (int c = 0; c < 15000; c++) begin
            int p;
            p = (c / 1000) % 3 == 0 ? 5 : (c / 1000) % 3 == 1 ? 40 : 95;
            din = 8'($urandom);
            din_valid = $urandom_range(0, 99) < p;
            reset = $urandom_range(0, 2999) != 0;
            tick();
        end
        reset = 1'b1;
        din_valid = 1'b0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
